pll_lock_reset_gen: RTL and testbench

PLL_LOCK_RESET_GEN -- requirements
Module: pll_lock_reset_gen

---
 rtl/pll_lock_reset_gen.sv | 130 +++++++++++++
 tb/tb_pll_lock_reset_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_gen.sv
// PLL lock qualification and fabric reset sequencer.
// Filters a synchronized PLL lock, holds reset off, then releases the fabric.
module pll_lock_reset_gen #(
  parameter int unsigned LOCK_FILTER_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES     = 1024
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       SW_RESET,
  input  logic       CLR_LOSS_CNT,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic [1:0] STATE,
  output logic [7:0] LOCK_LOSS_CNT
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

  logic        sync1_q;
  logic        lock_s_q;
  state_e      state_q, state_d;
  logic [15:0] filt_q, filt_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  loss_q, loss_d;
  logic        frn_q;
  logic        rdy_q;
  logic        loss;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= PLL_LOCK;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    loss    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = HOLDOFF;
          filt_d  = '0;
          hold_d  = '0;
        end else begin
          filt_d = filt_q + 16'd1;
        end
      end
      HOLDOFF: begin
        // Lock loss outranks a coincident software reset.
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
          loss    = 1'b1;
        end else if (SW_RESET) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
          loss    = 1'b1;
        end else if (SW_RESET) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        filt_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    loss_d = loss_q;
    if (CLR_LOSS_CNT) begin
      loss_d = {7'd0, loss};
    end else if (loss && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  // Outputs come straight from flops so the fabric never sees a glitch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      hold_q  <= '0;
      loss_q  <= '0;
      frn_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      loss_q  <= loss_d;
      frn_q   <= (state_d == RUN);
      rdy_q   <= frn_q;
    end
  end

  assign FABRIC_RESET_N = frn_q;
  assign READY          = rdy_q;
  assign STATE          = state_q;
  assign LOCK_LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Scoreboard bench for pll_lock_reset_gen (filter 4, holdoff 8).
// Expectations are queued with their edge index and checked as edges pass.
module tb_pll_lock_reset_gen;

  logic       CLK;
  logic       RESET;
  logic       PLL_LOCK;
  logic       SW_RESET;
  logic       CLR_LOSS_CNT;
  logic       FABRIC_RESET_N;
  logic       READY;
  logic [1:0] STATE;
  logic [7:0] LOCK_LOSS_CNT;

  pll_lock_reset_gen #(
    .LOCK_FILTER_CYCLES(4),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .PLL_LOCK(PLL_LOCK),
    .SW_RESET(SW_RESET),
    .CLR_LOSS_CNT(CLR_LOSS_CNT),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .READY(READY),
    .STATE(STATE),
    .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
  );

  typedef struct {
    int         at;
    string      nm;
    logic [1:0] st;
    logic       frn;
    logic       rdy;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   total;
  int   bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got hang want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push(input int at, input string nm,
                      input logic [1:0] st, input logic frn,
                      input logic rdy, input logic [7:0] cnt);
    exp_t e;
    e.at  = at;
    e.nm  = nm;
    e.st  = st;
    e.frn = frn;
    e.rdy = rdy;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    PLL_LOCK     = 1'b0;
    SW_RESET     = 1'b0;
    CLR_LOSS_CNT = 1'b0;
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !== 12'd0) begin
      bad++;
      $display("FAIL reset_async: got %h want 000",
               {STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT});
    end
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !== 12'd0) begin
      bad++;
      $display("FAIL reset_held: got %h want 000",
               {STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT});
    end
    RESET = 1'b0;
    cyc = 0;
    e.at = 0;
  endtask

  task automatic test_lock_acquire();
    exp_t e;
    int b;
    b = cyc;
    push(b + 2,  "acq_sync",    0, 0, 0, 0);
    push(b + 5,  "acq_filter",  0, 0, 0, 0);
    push(b + 6,  "acq_holdoff", 1, 0, 0, 0);
    push(b + 13, "acq_hold_end", 1, 0, 0, 0);
    push(b + 14, "acq_run",     2, 1, 0, 0);
    push(b + 15, "acq_ready",   2, 1, 1, 0);
    while (cyc < b + 16) begin
      if (cyc == b) PLL_LOCK = 1'b1;
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc - b, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
  endtask

  task automatic test_filter_glitch();
    exp_t e;
    int t;
    do_reset();
    push(6,  "glitch_clear",   0, 0, 0, 0);
    push(9,  "glitch_nohold",  0, 0, 0, 0);
    push(10, "glitch_holdoff", 1, 0, 0, 0);
    push(17, "glitch_hold_end", 1, 0, 0, 0);
    push(18, "glitch_run",     2, 1, 0, 0);
    while (cyc < 19) begin
      t = cyc;
      PLL_LOCK = (t != 3);
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int b;
    int t;
    b = cyc;
    push(b + 2,  "loss_still_run", 2, 1, 1, 0);
    push(b + 3,  "loss_drop",      0, 0, 1, 1);
    push(b + 4,  "loss_ready",     0, 0, 0, 1);
    push(b + 17, "relock_hold",    1, 0, 0, 1);
    push(b + 18, "relock_run",     2, 1, 0, 1);
    push(b + 19, "relock_ready",   2, 1, 1, 1);
    while (cyc < b + 20) begin
      t = cyc - b;
      if (t == 0) PLL_LOCK = 1'b0;
      if (t == 4) PLL_LOCK = 1'b1;
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc - b, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    exp_t e;
    int b;
    int t;
    b = cyc;
    push(b + 1,  "sw_holdoff",   1, 0, 1, 1);
    push(b + 2,  "sw_ready_low", 1, 0, 0, 1);
    push(b + 8,  "sw_hold_end",  1, 0, 0, 1);
    push(b + 9,  "sw_run",       2, 1, 0, 1);
    push(b + 13, "sw_vs_loss",   0, 0, 1, 2);
    push(b + 16, "sw_in_wait",   0, 0, 0, 2);
    push(b + 26, "sw_relock_hold", 1, 0, 0, 2);
    push(b + 27, "sw_relock_run",  2, 1, 0, 2);
    while (cyc < b + 28) begin
      t = cyc - b;
      SW_RESET = (t == 0) || (t == 12) || (t == 15);
      if (t == 10) PLL_LOCK = 1'b0;
      if (t == 13) PLL_LOCK = 1'b1;
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc - b, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
    SW_RESET = 1'b0;
  endtask

  task automatic test_reset_holdoff();
    exp_t e;
    int b;
    b = cyc;
    push(b + 1, "pre_reset_holdoff", 1, 0, 1, 2);
    while (cyc < b + 1) begin
      SW_RESET = 1'b1;
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
    SW_RESET = 1'b0;
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !== 12'd0) begin
      bad++;
      $display("FAIL holdoff_async_reset: got %h want 000",
               {STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT});
    end
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    cyc = 0;
    push(13, "restart_hold", 1, 0, 0, 0);
    push(14, "restart_run",  2, 1, 0, 0);
    while (cyc < 15) begin
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int t;
    int ks[6];
    ks = '{1, 10, 254, 255, 256, 300};
    do_reset();
    foreach (ks[i]) begin
      push(6 * ks[i] + 2, $sformatf("sat_k%0d", ks[i]), 0, 0, 0,
           (ks[i] > 255) ? 8'd255 : 8'(ks[i]));
    end
    push(6 * 301 + 2, "clr_with_loss", 0, 0, 0, 1);
    push(6 * 301 + 4, "clr_no_loss",   0, 0, 0, 0);
    while (cyc < 6 * 301 + 5) begin
      t = cyc;
      PLL_LOCK     = ((t % 6) != 5);
      CLR_LOSS_CNT = (t == 6 * 301 + 1) || (t == 6 * 301 + 3);
      step();
      while (q.size() != 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        total++;
        if ({STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT} !==
            {e.st, e.frn, e.rdy, e.cnt}) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d frn=%b rdy=%b cnt=%0d want st=%0d frn=%b rdy=%b cnt=%0d",
                   e.nm, cyc, STATE, FABRIC_RESET_N, READY, LOCK_LOSS_CNT,
                   e.st, e.frn, e.rdy, e.cnt);
        end
      end
    end
    CLR_LOSS_CNT = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc          = 0;
    RESET        = 1'b0;
    PLL_LOCK     = 1'b0;
    SW_RESET     = 1'b0;
    CLR_LOSS_CNT = 1'b0;
    test_reset();
    test_lock_acquire();
    test_filter_glitch();
    test_lock_loss();
    test_sw_reset();
    test_reset_holdoff();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
